// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and a frame-length helper.
// Used by both the transmitter and the receiver side.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clock cycles one complete frame occupies on the line.
  function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
    return (1 + DATA_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the transmitter. A byte moves on a clk edge where valid && ready;
// the source holds data and valid until then, and ready may drop on any edge after acceptance.
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: tick is high on the last clock of every CLKS_PER_BIT window.
// restart holds the count at zero so the first window after release is full width.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
  // High when the following cycle will be a tick cycle (always, at one clock per bit).
  assign tick_next = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes a byte per valid/ready handshake and sends it as an 8N1 or 8N2 frame,
// LSB first, on a registered tx line that idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_tx_if.slave    bus,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output uart_state_e state
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 ready_q;
  logic                 tick;
  logic                 tick_next;
  logic                 done_next;

  assign bus.ready = ready_q;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (state == ST_IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // done is registered, so raise it on the edge that starts the final stop-bit cycle.
  always_comb begin
    done_next = 1'b0;
    if (tick_next) begin
      if (state == ST_STOP && !tick && stop_idx == LAST_STOP)
        done_next = 1'b1;
      else if (state == ST_STOP && tick && STOP_BITS == 2 && stop_idx == 1'b0)
        done_next = 1'b1;
      else if (state == ST_DATA && tick && bit_idx == LAST_BIT && STOP_BITS == 1)
        done_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_next;
      case (state)
        ST_IDLE: begin
          if (bus.valid && ready_q) begin
            shift   <= bus.data;
            tx      <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= ST_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              ready_q <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a 4-clock/bit 8N1 instance checked frame by frame against a scoreboard,
// and a 1-clock/bit 8N2 instance checked cycle by cycle.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB    = 4;
  localparam int FRAME4 = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if bus4();
  uart_tx_if bus1();
  logic tx4, busy4, done4, tx1, busy1, done1;
  uart_state_e state4, state1;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .tx(tx4), .busy(busy4), .done(done4), .state(state4));
  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .tx(tx1), .busy(busy1), .done(done1), .state(state1));

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  int gap_q[$];
  int frames_seen = 0;
  int aborts = 0;
  int last_end = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;     // bit k = k-th bit on the line: start, d0..d7, stop
    int         gap;       // required idle cycles before this frame, -1 = any
    bit         keep;      // keep valid high after acceptance
    int         delay;     // cycles to wait before offering
    bit         wait_done; // wait for the frame to finish before the next entry
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic [9:0] f, input int egap, input bit keep);
    int waited = 0;
    bus4.data  = d;
    bus4.valid = 1'b1;
    while (!bus4.ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!bus4.ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: ready stayed 0 for byte 0x%0h", d);
      bus4.valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(f);
    gap_q.push_back(egap);
    #1;
    if (!keep) bus4.valid = 1'b0;
    bus4.data = 8'hFF;
  endtask

  task automatic wait_frames(input int n);
    int w = 0;
    while (frames_seen < n && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("frames_seen", frames_seen, n);
  endtask

  // Monitor: decodes every dut4 frame and compares it with the scoreboard.
  initial begin
    logic [9:0] obs, expf;
    int egap, gap, done_cnt, done_pos;
    bit aborted, steady;
    forever begin
      @(negedge clk);
      if (rst_n && busy4) begin
        if (exp_q.size() == 0) begin
          expf = '0;
          egap = -1;
          checks++;
          failures++;
          $display("FAIL unexpected_frame: frame started with empty scoreboard at t=%0t", $time);
        end else begin
          expf = exp_q.pop_front();
          egap = gap_q.pop_front();
        end
        gap = cyc - last_end - 1;
        obs = '0;
        done_cnt = 0;
        done_pos = -1;
        aborted = 1'b0;
        steady = 1'b1;
        for (int k = 0; k < FRAME4; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) obs[k / CPB] = tx4;
          else if (tx4 !== obs[k / CPB]) steady = 1'b0;
          if (busy4 !== 1'b1) steady = 1'b0;
          if (done4) begin
            done_cnt++;
            done_pos = k;
          end
        end
        if (aborted) begin
          aborts++;
        end else begin
          last_end = cyc;
          check("frame_bits", obs, expf);
          check("bit_width_busy", steady, 1);
          check("done_count", done_cnt, 1);
          check("done_pos", done_pos, FRAME4 - 1);
          if (egap >= 0) check("idle_gap", gap, egap);
          @(negedge clk);
          check("post_frame_tx_ready_busy_done", {tx4, bus4.ready, busy4, done4}, 4'b1100);
          frames_seen++;
        end
      end
    end
  end

  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0]  d;
    logic [10:0] obs1, done_vec, busy_vec;
    logic [7:0]  d1[2];
    logic [10:0] f1[2];
    int n = 0;

    tbl[0] = '{8'h55, 10'h2AA, -1, 1'b0, 0,  1'b1};
    tbl[1] = '{8'hA5, 10'h34A, -1, 1'b1, 0,  1'b0};
    tbl[2] = '{8'h3C, 10'h278,  1, 1'b0, 0,  1'b1};
    tbl[3] = '{8'h5A, 10'h2B4, -1, 1'b0, 0,  1'b0};
    tbl[4] = '{8'hC3, 10'h386,  1, 1'b0, 10, 1'b1};
    tbl[5] = '{8'hFF, 10'h3FE, -1, 1'b0, 3,  1'b1};
    tbl[6] = '{8'h00, 10'h200, -1, 1'b0, 0,  1'b1};
    d1[0] = 8'h00; f1[0] = 11'h600;
    d1[1] = 8'hF0; f1[1] = 11'h7E0;

    bus4.valid = 1'b0;
    bus4.data  = 'x;
    bus1.valid = 1'b0;
    bus1.data  = 'x;

    // Reset values while rst_n is low.
    #12;
    check("reset4_outputs", {tx4, bus4.ready, busy4, done4}, 4'b1100);
    check("reset4_state", state4, ST_IDLE);
    check("reset1_outputs", {tx1, bus1.ready, busy1, done1}, 4'b1100);
    check("reset1_state", state1, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet line after reset.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle4", {tx4, bus4.ready, busy4, done4}, 4'b1100);
      check("idle1", {tx1, bus1.ready, busy1, done1}, 4'b1100);
    end

    // Table: single frames, back-to-back, hold-off with data changed mid-frame.
    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].delay) @(negedge clk);
      offer(tbl[i].data, tbl[i].frame, tbl[i].gap, tbl[i].keep);
      n++;
      if (tbl[i].wait_done) wait_frames(n);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = 8'($urandom_range(0, 255));
      offer(d, {1'b1, d, 1'b0}, -1, 1'b0);
      n++;
      wait_frames(n);
    end

    // Reset during data bit 3 of 0xB7 (bit 3 is 0 on the line).
    @(negedge clk);
    offer(8'hB7, 10'h36E, -1, 1'b0);
    repeat (18) @(negedge clk);
    check("pre_reset_state", state4, ST_DATA);
    check("pre_reset_tx", tx4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {tx4, bus4.ready, busy4, done4}, 4'b1100);
    check("midframe_reset_state", state4, ST_IDLE);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    offer(8'h81, 10'h302, -1, 1'b0);
    n++;
    wait_frames(n);
    check("aborted_frames", aborts, 1);

    // 8N2 at one clock per bit, cycle-accurate.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus1.data  = d1[i];
      bus1.valid = 1'b1;
      check("dut1_ready_before", bus1.ready, 1'b1);
      @(posedge clk);
      #1;
      bus1.valid = 1'b0;
      bus1.data  = 8'hFF;
      obs1 = '0;
      done_vec = '0;
      busy_vec = '0;
      for (int k = 0; k < 11; k++) begin
        @(negedge clk);
        obs1[k] = tx1;
        done_vec[k] = done1;
        busy_vec[k] = busy1;
      end
      check("dut1_tx_seq", obs1, f1[i]);
      check("dut1_done_seq", done_vec, 11'h400);
      check("dut1_busy_seq", busy_vec, 11'h7FF);
      @(negedge clk);
      check("dut1_post_frame", {tx1, bus1.ready, busy1, done1}, 4'b1100);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
